pmem_wb_arbiter: RTL and testbench

PMEM_WB_ARBITER -- requirements
Module: pmem_wb_arbiter

---
 rtl/pmem_wb_arbiter_pkg.sv | 25 ++
 rtl/pmem_wb_arbiter_wb_entry.sv | 62 ++++++
 rtl/pmem_wb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_pmem_wb_arbiter.sv | 502 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmem_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_types
//   Shared definitions for the physical-memory arbiter and its write buffer:
//   the arbiter state encoding, the cache-line offset width and a helper that
//   compares two byte addresses at cache-line granularity.
// -----------------------------------------------------------------------------
package rv32i_types;

    // A 256-bit line is 32 bytes, so address bits [4:0] select a byte within it.
    localparam int unsigned LINE_OFFSET = 5;
    localparam logic [31:0] LINE_MASK   = ~((32'd1 << LINE_OFFSET) - 32'd1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_D = 2'b01,
        SERVE_I = 2'b10,
        DRAIN   = 2'b11
    } pmem_arb_state_e;

    // Two addresses refer to the same line when they differ only in the offset bits.
    function automatic logic same_line(input logic [31:0] a, input logic [31:0] b);
        return ((a ^ b) & LINE_MASK) == 32'd0;
    endfunction

endpackage

// File: rtl/pmem_wb_arbiter_wb_entry.sv
// -----------------------------------------------------------------------------
// wb_entry
//   One-entry write buffer holding a D-cache write-back line (valid, address,
//   data) plus line-match logic against the current D- and I-cache addresses.
//
//   clk, rst    : clock, synchronous active-high reset (clears the entry)
//   load_i      : capture addr_i/data_i and set valid
//   clear_i     : drop valid (line has been written to memory)
//   addr_i      : address to capture
//   data_i      : line to capture
//   d_addr_i    : D-cache address to compare
//   i_addr_i    : I-cache address to compare
//   valid_o     : entry holds a line
//   addr_o      : buffered address
//   data_o      : buffered line
//   d_hit_o     : valid and d_addr_i is on the buffered line
//   i_hit_o     : valid and i_addr_i is on the buffered line
// -----------------------------------------------------------------------------
module wb_entry
    import rv32i_types::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic [31:0]  d_addr_i,
    input  logic [31:0]  i_addr_i,
    output logic         valid_o,
    output logic [31:0]  addr_o,
    output logic [255:0] data_o,
    output logic         d_hit_o,
    output logic         i_hit_o
);

    logic         valid_q;
    logic [31:0]  addr_q;
    logic [255:0] data_q;

    // load and clear are issued from different arbiter states, never together.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            addr_q  <= addr_i;
            data_q  <= data_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign d_hit_o = valid_q && same_line(addr_q, d_addr_i);
    assign i_hit_o = valid_q && same_line(addr_q, i_addr_i);

endmodule

// File: rtl/pmem_wb_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_wb_arbiter
//   Arbitrates one physical memory port between an I-cache (read only) and a
//   D-cache (read / write-back), with a one-entry write buffer that absorbs
//   D-cache write-backs and forwards buffered data to same-line reads.
//
//   clk, rst             : clock, synchronous active-high reset
//   i_pmem_read/address  : I-cache line read request (held until i_pmem_resp)
//   i_pmem_rdata/resp    : line and one-cycle completion pulse to I-cache
//   d_pmem_read/write    : D-cache requests (exclusive, held until d_pmem_resp)
//   d_pmem_address/wdata : D-cache line address and write-back data
//   d_pmem_rdata/resp    : line and one-cycle completion pulse to D-cache
//   a_pmem_read/write    : memory request strobes (never both high)
//   a_pmem_address/wdata : memory address and write data
//   a_pmem_rdata/resp    : memory read data and completion
// -----------------------------------------------------------------------------
module pmem_wb_arbiter
    import rv32i_types::*;
(
    input  logic         clk,
    input  logic         rst,

    input  logic         i_pmem_read,
    input  logic [31:0]  i_pmem_address,
    output logic [255:0] i_pmem_rdata,
    output logic         i_pmem_resp,

    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic [31:0]  d_pmem_address,
    input  logic [255:0] d_pmem_wdata,
    output logic [255:0] d_pmem_rdata,
    output logic         d_pmem_resp,

    output logic         a_pmem_read,
    output logic         a_pmem_write,
    output logic [31:0]  a_pmem_address,
    output logic [255:0] a_pmem_wdata,
    input  logic [255:0] a_pmem_rdata,
    input  logic         a_pmem_resp
);

    pmem_arb_state_e state_q, state_d;
    logic [31:0]     req_addr_q, req_addr_d;

    logic         wb_load;
    logic         wb_clear;
    logic         wb_valid;
    logic [31:0]  wb_addr;
    logic [255:0] wb_data;
    logic         wb_d_hit;
    logic         wb_i_hit;

    wb_entry u_wb (
        .clk      (clk),
        .rst      (rst),
        .load_i   (wb_load),
        .clear_i  (wb_clear),
        .addr_i   (d_pmem_address),
        .data_i   (d_pmem_wdata),
        .d_addr_i (d_pmem_address),
        .i_addr_i (i_pmem_address),
        .valid_o  (wb_valid),
        .addr_o   (wb_addr),
        .data_o   (wb_data),
        .d_hit_o  (wb_d_hit),
        .i_hit_o  (wb_i_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Memory-side outputs are decoded only from registered state (state_q,
    // req_addr_q, buffer contents), so they stay constant for a whole request.
    // Cache-side responses in IDLE are combinational so buffer hits complete in
    // the request cycle. Everything is held at zero while rst is high so an
    // abandoned transaction cannot leak a response.
    always_comb begin
        state_d        = state_q;
        req_addr_d     = req_addr_q;
        wb_load        = 1'b0;
        wb_clear       = 1'b0;
        i_pmem_rdata   = '0;
        i_pmem_resp    = 1'b0;
        d_pmem_rdata   = '0;
        d_pmem_resp    = 1'b0;
        a_pmem_read    = 1'b0;
        a_pmem_write   = 1'b0;
        a_pmem_address = '0;
        a_pmem_wdata   = '0;

        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (d_pmem_write) begin
                        if (!wb_valid || wb_d_hit) begin
                            wb_load     = 1'b1;
                            d_pmem_resp = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else if (d_pmem_read) begin
                        if (wb_d_hit) begin
                            d_pmem_rdata = wb_data;
                            d_pmem_resp  = 1'b1;
                        end else begin
                            state_d    = SERVE_D;
                            req_addr_d = d_pmem_address;
                        end
                    end else if (i_pmem_read) begin
                        if (wb_i_hit) begin
                            i_pmem_rdata = wb_data;
                            i_pmem_resp  = 1'b1;
                        end else begin
                            state_d    = SERVE_I;
                            req_addr_d = i_pmem_address;
                        end
                    end else if (wb_valid) begin
                        state_d = DRAIN;
                    end
                end
                SERVE_D: begin
                    a_pmem_read    = 1'b1;
                    a_pmem_address = req_addr_q;
                    if (a_pmem_resp) begin
                        d_pmem_rdata = a_pmem_rdata;
                        d_pmem_resp  = 1'b1;
                        state_d      = IDLE;
                    end
                end
                SERVE_I: begin
                    a_pmem_read    = 1'b1;
                    a_pmem_address = req_addr_q;
                    if (a_pmem_resp) begin
                        i_pmem_rdata = a_pmem_rdata;
                        i_pmem_resp  = 1'b1;
                        state_d      = IDLE;
                    end
                end
                DRAIN: begin
                    a_pmem_write   = 1'b1;
                    a_pmem_address = wb_addr;
                    a_pmem_wdata   = wb_data;
                    if (a_pmem_resp) begin
                        wb_clear = 1'b1;
                        state_d  = IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmem_wb_arbiter.sv
module tb_pmem_wb_arbiter;

    logic         clk;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         a_pmem_read;
    logic         a_pmem_write;
    logic [31:0]  a_pmem_address;
    logic [255:0] a_pmem_wdata;
    logic [255:0] a_pmem_rdata;
    logic         a_pmem_resp;

    int checks = 0;
    int errors = 0;

    int mem_lat = 2;
    int mcnt = 0;
    int mem_reads = 0;
    int mem_writes = 0;
    int mem_wr_cycles = 0;
    int d_resp_cnt = 0;
    int i_resp_cnt = 0;
    logic [31:0]  last_waddr = '0;
    logic [255:0] last_wdata = '0;

    logic [255:0] DATA_A;
    logic [255:0] DATA_B;
    logic [255:0] DATA_C;

    pmem_wb_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .a_pmem_read    (a_pmem_read),
        .a_pmem_write   (a_pmem_write),
        .a_pmem_address (a_pmem_address),
        .a_pmem_wdata   (a_pmem_wdata),
        .a_pmem_rdata   (a_pmem_rdata),
        .a_pmem_resp    (a_pmem_resp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [255:0] mline(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    // Memory model: responds mem_lat cycles after a request appears.
    initial begin
        a_pmem_resp  = 1'b0;
        a_pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (a_pmem_resp) begin
                a_pmem_resp  = 1'b0;
                a_pmem_rdata = '0;
                mcnt         = 0;
            end else if (a_pmem_read || a_pmem_write) begin
                mcnt++;
                if (mcnt >= mem_lat) begin
                    a_pmem_resp = 1'b1;
                    mcnt        = 0;
                    if (a_pmem_read) begin
                        a_pmem_rdata = mline(a_pmem_address);
                        mem_reads++;
                    end else begin
                        mem_writes++;
                        last_waddr = a_pmem_address;
                        last_wdata = a_pmem_wdata;
                    end
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    // Per-cycle protocol monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (a_pmem_write) mem_wr_cycles++;
            if (d_pmem_resp) d_resp_cnt++;
            if (i_pmem_resp) i_resp_cnt++;
            checks++;
            if (a_pmem_read && a_pmem_write) begin
                errors++;
                $display("FAIL mem_rw_both: read=%b write=%b required not both", a_pmem_read, a_pmem_write);
            end
            checks++;
            if (d_pmem_resp && i_pmem_resp) begin
                errors++;
                $display("FAIL two_resp: d=%b i=%b required at most one", d_pmem_resp, i_pmem_resp);
            end
            checks++;
            if (!d_pmem_resp && d_pmem_rdata !== '0) begin
                errors++;
                $display("FAIL d_rdata_idle: got %h required 0", d_pmem_rdata);
            end
            checks++;
            if (!i_pmem_resp && i_pmem_rdata !== '0) begin
                errors++;
                $display("FAIL i_rdata_idle: got %h required 0", i_pmem_rdata);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wait helpers: called at a drive point, return at the negedge where the
    // event was seen (n = cycles waited) or n = -1 after maxc cycles.
    task automatic wait_d(input int maxc, output int n, output logic [255:0] rd);
        n = -1;
        rd = '0;
        for (int k = 0; k < maxc; k++) begin
            if (k > 0) cyc();
            @(negedge clk);
            if (d_pmem_resp) begin
                n = k;
                rd = d_pmem_rdata;
                break;
            end
        end
    endtask

    task automatic wait_i(input int maxc, output int n, output logic [255:0] rd);
        n = -1;
        rd = '0;
        for (int k = 0; k < maxc; k++) begin
            if (k > 0) cyc();
            @(negedge clk);
            if (i_pmem_resp) begin
                n = k;
                rd = i_pmem_rdata;
                break;
            end
        end
    endtask

    task automatic wait_mem(input int maxc, output int n);
        n = -1;
        for (int k = 0; k < maxc; k++) begin
            if (k > 0) cyc();
            @(negedge clk);
            if (a_pmem_resp) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_pmem_read, a_pmem_write, d_pmem_resp, i_pmem_resp} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 0000",
                     {a_pmem_read, a_pmem_write, d_pmem_resp, i_pmem_resp});
        end
        checks++;
        if (a_pmem_address !== 32'h0 || a_pmem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_mem_bus: addr %h wdata %h required 0", a_pmem_address, a_pmem_wdata);
        end
        cyc();
        cyc();
        @(negedge clk);
        checks++;
        if (mem_wr_cycles !== 0 || a_pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_traffic: wr_cycles %0d read %b required 0 0", mem_wr_cycles, a_pmem_read);
        end
        cyc();
    endtask

    task automatic test_write_drain();
        int n;
        int w0;
        mem_lat = 2;
        w0 = mem_writes;
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_1000;
        d_pmem_wdata = DATA_A;
        @(negedge clk);
        checks++;
        if (d_pmem_resp !== 1'b1 || a_pmem_read !== 1'b0 || a_pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL wr_capture: resp %b mem r/w %b%b required 1 00", d_pmem_resp, a_pmem_read, a_pmem_write);
        end
        cyc();
        d_pmem_write = 1'b0;
        @(negedge clk);
        checks++;
        if (a_pmem_write !== 1'b0 || d_pmem_resp !== 1'b0) begin
            errors++;
            $display("FAIL wr_idle_gap: write %b resp %b required 0 0", a_pmem_write, d_pmem_resp);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (a_pmem_write !== 1'b1 || a_pmem_address !== 32'h0000_1000 || a_pmem_wdata !== DATA_A) begin
            errors++;
            $display("FAIL drain_req: write %b addr %h wdata %h required 1 00001000 %h",
                     a_pmem_write, a_pmem_address, a_pmem_wdata, DATA_A);
        end
        cyc();
        wait_mem(10, n);
        checks++;
        if (n < 0) begin
            errors++;
            $display("FAIL drain_timeout: got no a_pmem_resp required one within 10 cycles");
        end
        cyc();
        repeat (4) cyc();
        @(negedge clk);
        checks++;
        if (mem_writes - w0 !== 1 || last_waddr !== 32'h0000_1000 || a_pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL drain_once: writes %0d addr %h write %b required 1 00001000 0",
                     mem_writes - w0, last_waddr, a_pmem_write);
        end
        cyc();
    endtask

    task automatic test_wb_forward();
        int n;
        int r0;
        mem_lat = 2;
        r0 = mem_reads;
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_1000;
        d_pmem_wdata = DATA_A;
        @(negedge clk);
        checks++;
        if (d_pmem_resp !== 1'b1) begin
            errors++;
            $display("FAIL fwd_capture: resp %b required 1", d_pmem_resp);
        end
        cyc();
        d_pmem_write = 1'b0;
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_1004;
        @(negedge clk);
        checks++;
        if (d_pmem_resp !== 1'b1 || d_pmem_rdata !== DATA_A || a_pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL fwd_d: resp %b rdata %h memread %b required 1 %h 0",
                     d_pmem_resp, d_pmem_rdata, a_pmem_read, DATA_A);
        end
        cyc();
        d_pmem_read = 1'b0;
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_1010;
        @(negedge clk);
        checks++;
        if (i_pmem_resp !== 1'b1 || i_pmem_rdata !== DATA_A || a_pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL fwd_i: resp %b rdata %h memread %b required 1 %h 0",
                     i_pmem_resp, i_pmem_rdata, a_pmem_read, DATA_A);
        end
        cyc();
        i_pmem_read = 1'b0;
        wait_mem(10, n);
        cyc();
        cyc();
        @(negedge clk);
        checks++;
        if (n < 0 || mem_reads !== r0) begin
            errors++;
            $display("FAIL fwd_no_memread: drain wait %0d reads %0d required >=0 %0d", n, mem_reads, r0);
        end
        cyc();
    endtask

    task automatic test_conflict_drain();
        int n;
        int w0;
        logic [255:0] rd;
        mem_lat = 2;
        w0 = mem_writes;
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_1000;
        d_pmem_wdata = DATA_A;
        @(negedge clk);
        cyc();
        d_pmem_address = 32'h0000_2000;
        d_pmem_wdata = DATA_C;
        @(negedge clk);
        checks++;
        if (d_pmem_resp !== 1'b0) begin
            errors++;
            $display("FAIL conflict_no_resp: resp %b required 0", d_pmem_resp);
        end
        cyc();
        wait_d(20, n, rd);
        checks++;
        if (n < 0 || mem_writes - w0 !== 1 || last_waddr !== 32'h0000_1000 || last_wdata !== DATA_A) begin
            errors++;
            $display("FAIL conflict_drain_first: wait %0d writes %0d addr %h required >=0 1 00001000",
                     n, mem_writes - w0, last_waddr);
        end
        cyc();
        d_pmem_write = 1'b0;
        wait_mem(20, n);
        cyc();
        @(negedge clk);
        checks++;
        if (n < 0 || mem_writes - w0 !== 2 || last_waddr !== 32'h0000_2000 || last_wdata !== DATA_C) begin
            errors++;
            $display("FAIL conflict_second: wait %0d writes %0d addr %h data %h required >=0 2 00002000 %h",
                     n, mem_writes - w0, last_waddr, last_wdata, DATA_C);
        end
        cyc();
    endtask

    task automatic test_dual_read();
        int n;
        int r0;
        int dc0;
        int ic0;
        logic [255:0] rd;
        mem_lat = 3;
        r0 = mem_reads;
        dc0 = d_resp_cnt;
        ic0 = i_resp_cnt;
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_3000;
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_4000;
        wait_d(20, n, rd);
        checks++;
        if (n < 0 || rd !== mline(32'h0000_3000) || i_resp_cnt !== ic0) begin
            errors++;
            $display("FAIL dual_d_first: wait %0d rdata %h i_resps %0d required >=0 %h 0",
                     n, rd, i_resp_cnt - ic0, mline(32'h0000_3000));
        end
        cyc();
        d_pmem_read = 1'b0;
        wait_i(20, n, rd);
        checks++;
        if (n < 0 || rd !== mline(32'h0000_4000)) begin
            errors++;
            $display("FAIL dual_i_second: wait %0d rdata %h required >=0 %h", n, rd, mline(32'h0000_4000));
        end
        cyc();
        i_pmem_read = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        checks++;
        if (d_resp_cnt - dc0 !== 1 || i_resp_cnt - ic0 !== 1 || mem_reads - r0 !== 2) begin
            errors++;
            $display("FAIL dual_counts: d %0d i %0d reads %0d required 1 1 2",
                     d_resp_cnt - dc0, i_resp_cnt - ic0, mem_reads - r0);
        end
        cyc();
    endtask

    task automatic test_reset_mid_serve();
        int ic0;
        int wc0;
        mem_lat = 10;
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_1000;
        d_pmem_wdata = DATA_A;
        @(negedge clk);
        cyc();
        d_pmem_write = 1'b0;
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_5000;
        @(negedge clk);
        cyc();
        @(negedge clk);
        checks++;
        if (a_pmem_read !== 1'b1 || a_pmem_address !== 32'h0000_5000) begin
            errors++;
            $display("FAIL serve_i_req: read %b addr %h required 1 00005000", a_pmem_read, a_pmem_address);
        end
        ic0 = i_resp_cnt;
        cyc();
        rst = 1'b1;
        i_pmem_read = 1'b0;
        @(negedge clk);
        cyc();
        rst = 1'b0;
        wc0 = mem_wr_cycles;
        @(negedge clk);
        checks++;
        if ({a_pmem_read, a_pmem_write, d_pmem_resp, i_pmem_resp} !== 4'b0000 ||
            a_pmem_address !== 32'h0 || a_pmem_wdata !== '0) begin
            errors++;
            $display("FAIL rst_outputs: strobes %b addr %h required 0000 00000000",
                     {a_pmem_read, a_pmem_write, d_pmem_resp, i_pmem_resp}, a_pmem_address);
        end
        repeat (6) cyc();
        @(negedge clk);
        checks++;
        if (mem_wr_cycles !== wc0 || i_resp_cnt !== ic0) begin
            errors++;
            $display("FAIL rst_abandon: write cycles %0d i_resps %0d required 0 0",
                     mem_wr_cycles - wc0, i_resp_cnt - ic0);
        end
        cyc();
    endtask

    task automatic test_same_line_twice();
        int n;
        int w0;
        mem_lat = 2;
        w0 = mem_writes;
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_1000;
        d_pmem_wdata = DATA_A;
        @(negedge clk);
        checks++;
        if (d_pmem_resp !== 1'b1) begin
            errors++;
            $display("FAIL same_line_first: resp %b required 1", d_pmem_resp);
        end
        cyc();
        d_pmem_wdata = DATA_B;
        @(negedge clk);
        checks++;
        if (d_pmem_resp !== 1'b1 || a_pmem_write !== 1'b0) begin
            errors++;
            $display("FAIL same_line_second: resp %b write %b required 1 0", d_pmem_resp, a_pmem_write);
        end
        cyc();
        d_pmem_write = 1'b0;
        wait_mem(10, n);
        cyc();
        repeat (3) cyc();
        @(negedge clk);
        checks++;
        if (n < 0 || mem_writes - w0 !== 1 || last_waddr !== 32'h0000_1000 || last_wdata !== DATA_B) begin
            errors++;
            $display("FAIL same_line_drain: wait %0d writes %0d addr %h data %h required >=0 1 00001000 %h",
                     n, mem_writes - w0, last_waddr, last_wdata, DATA_B);
        end
        cyc();
    endtask

    initial begin
        DATA_A = {8{32'hAAAA_0001}};
        DATA_B = {8{32'hBBBB_0002}};
        DATA_C = {8{32'hCCCC_0003}};
        rst = 1'b1;
        i_pmem_read = 1'b0;
        i_pmem_address = '0;
        d_pmem_read = 1'b0;
        d_pmem_write = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata = '0;
        cyc();

        test_reset();
        test_write_drain();
        test_wb_forward();
        test_conflict_drain();
        test_dual_read();
        test_reset_mid_serve();
        test_same_line_twice();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
